// File: rtl/bimodal_predictor.sv
// Bimodal branch predictor: a table of saturating counters with a one-cycle lookup.
// A same-cycle update to the looked-up entry is bypassed into the prediction.

module bimodal_predictor_counter #(
   parameter int RANGE       = 4,
   parameter int RESET_VALUE = 1,
   parameter int COUNT_WIDTH = 2
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   update,
   input  logic                   taken,
   output logic [COUNT_WIDTH-1:0] count,
   output logic [COUNT_WIDTH-1:0] next_count
);
   localparam logic [COUNT_WIDTH-1:0] MAX = COUNT_WIDTH'(RANGE - 1);

   // next_count is always computed so the top can bypass it to a same-cycle lookup
   always_comb begin
      next_count = count;
      if (taken && count != MAX)
         next_count = count + 1'b1;
      else if (!taken && count != '0)
         next_count = count - 1'b1;
   end

   always_ff @(posedge clock) begin
      if (reset)
         count <= COUNT_WIDTH'(RESET_VALUE);
      else if (update)
         count <= next_count;
   end
endmodule

module bimodal_predictor #(
   parameter  int DEPTH       = 16,
   parameter  int RANGE       = 4,
   parameter  int RESET_VALUE = 1,
   localparam int INDEX_WIDTH = $clog2(DEPTH),
   localparam int COUNT_WIDTH = $clog2(RANGE)
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   predict_valid,
   input  logic [INDEX_WIDTH-1:0] predict_index,
   output logic                   prediction_valid,
   output logic                   prediction_taken,
   output logic [COUNT_WIDTH-1:0] prediction_count,
   input  logic                   update_valid,
   input  logic [INDEX_WIDTH-1:0] update_index,
   input  logic                   update_taken
);
   localparam logic [COUNT_WIDTH-1:0] HALF = COUNT_WIDTH'(RANGE / 2);

   logic [DEPTH-1:0][COUNT_WIDTH-1:0] count_q;
   logic [DEPTH-1:0][COUNT_WIDTH-1:0] next_q;
   logic [COUNT_WIDTH-1:0]            lookup_count;

   for (genvar g = 0; g < DEPTH; g++) begin : g_entry
      bimodal_predictor_counter #(
         .RANGE       (RANGE),
         .RESET_VALUE (RESET_VALUE),
         .COUNT_WIDTH (COUNT_WIDTH)
      ) u_counter (
         .clock      (clock),
         .reset      (reset),
         .update     (update_valid && update_index == INDEX_WIDTH'(g)),
         .taken      (update_taken),
         .count      (count_q[g]),
         .next_count (next_q[g])
      );
   end

   // write-first: a lookup of the entry being trained sees the trained value
   always_comb begin
      lookup_count = count_q[predict_index];
      if (update_valid && update_index == predict_index)
         lookup_count = next_q[update_index];
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         prediction_valid <= 1'b0;
         prediction_count <= COUNT_WIDTH'(RESET_VALUE);
         prediction_taken <= (RESET_VALUE >= RANGE / 2);
      end else begin
         prediction_valid <= predict_valid;
         if (predict_valid) begin
            prediction_count <= lookup_count;
            prediction_taken <= (lookup_count >= HALF);
         end
      end
   end
endmodule

// File: tb/tb_bimodal_predictor.sv
// Bench for bimodal_predictor: directed scenarios with literal expectations plus a
// random phase, all outputs compared every cycle against an integer table model.

module tb_bimodal_predictor;
   localparam int DEPTH = 16;
   localparam int RANGE = 4;
   localparam int RV    = 1;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic       predict_valid = 1'b0;
   logic [3:0] predict_index = '0;
   logic       prediction_valid;
   logic       prediction_taken;
   logic [1:0] prediction_count;
   logic       update_valid = 1'b0;
   logic [3:0] update_index = '0;
   logic       update_taken = 1'b0;

   int tests = 0;
   int fails = 0;

   bimodal_predictor #(.DEPTH(DEPTH), .RANGE(RANGE), .RESET_VALUE(RV)) dut (
      .clock            (clock),
      .reset            (reset),
      .predict_valid    (predict_valid),
      .predict_index    (predict_index),
      .prediction_valid (prediction_valid),
      .prediction_taken (prediction_taken),
      .prediction_count (prediction_count),
      .update_valid     (update_valid),
      .update_index     (update_index),
      .update_taken     (update_taken)
   );

   always #5 clock = ~clock;

   // reference model: plain integer table, arithmetic with clamping
   int  tbl [DEPTH];
   int  exp_count = RV;
   bit  exp_valid = 1'b0;
   bit  model_live = 1'b0;

   function automatic int trained(input int c, input bit t);
      int n;
      n = t ? c + 1 : c - 1;
      if (n > RANGE - 1) n = RANGE - 1;
      if (n < 0) n = 0;
      return n;
   endfunction

   always @(posedge clock) begin
      if (reset) begin
         for (int i = 0; i < DEPTH; i++) tbl[i] <= RV;
         exp_valid  <= 1'b0;
         exp_count  <= RV;
         model_live <= 1'b1;
      end else begin
         exp_valid <= predict_valid;
         if (update_valid)
            tbl[update_index] <= trained(tbl[update_index], update_taken);
         if (predict_valid) begin
            if (update_valid && update_index == predict_index)
               exp_count <= trained(tbl[predict_index], update_taken);
            else
               exp_count <= tbl[predict_index];
         end
      end
   end

   task automatic check(input string name, input int act, input int req);
      tests++;
      if (act != req) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
      end
   endtask

   always @(negedge clock) begin
      if (model_live) begin
         check("model_valid", prediction_valid, exp_valid);
         check("model_count", prediction_count, exp_count);
         check("model_taken", prediction_taken, exp_count >= RANGE / 2);
      end
   end

   // drive one cycle of inputs, return after the edge at the following negedge
   task automatic cyc(input bit pv, input int pi, input bit uv, input int ui, input bit ut);
      predict_valid = pv;
      predict_index = pi[3:0];
      update_valid  = uv;
      update_index  = ui[3:0];
      update_taken  = ut;
      @(negedge clock);
   endtask

   task automatic expect_pred(input string name, input int cnt, input bit tkn);
      check({name, "_valid"}, prediction_valid, 1);
      check({name, "_count"}, prediction_count, cnt);
      check({name, "_taken"}, prediction_taken, tkn);
   endtask

   initial begin
      @(negedge clock);
      reset = 1'b1;
      cyc(0, 0, 0, 0, 0);
      reset = 1'b0;
      check("rst_valid", prediction_valid, 0);
      check("rst_count", prediction_count, 1);
      check("rst_taken", prediction_taken, 0);

      for (int i = 0; i < DEPTH; i++) begin
         cyc(1, i, 0, 0, 0);
         expect_pred("rst_entry", 1, 0);
      end
      cyc(0, 0, 0, 0, 0);
      check("idle_valid", prediction_valid, 0);
      check("idle_hold", prediction_count, 1);

      // upward saturation on index 3
      for (int k = 0; k < 5; k++) cyc(0, 0, 1, 3, 1);
      cyc(1, 3, 0, 0, 0);
      expect_pred("sat_up", 3, 1);
      cyc(1, 2, 0, 0, 0);
      expect_pred("neighbour2", 1, 0);
      cyc(1, 4, 0, 0, 0);
      expect_pred("neighbour4", 1, 0);

      // downward saturation
      for (int k = 0; k < 3; k++) cyc(0, 0, 1, 3, 0);
      cyc(1, 3, 0, 0, 0);
      expect_pred("sat_down", 0, 0);
      cyc(0, 0, 1, 3, 0);
      cyc(1, 3, 0, 0, 0);
      expect_pred("sat_floor", 0, 0);

      // write-first bypass
      cyc(1, 5, 1, 5, 1);
      expect_pred("bypass", 2, 1);
      cyc(1, 6, 1, 9, 1);
      expect_pred("indep_pred", 1, 0);
      cyc(1, 9, 0, 0, 0);
      expect_pred("indep_upd", 2, 1);

      // reset mid-operation discards the same-edge predict and update
      cyc(0, 0, 1, 7, 1);
      cyc(0, 0, 1, 7, 1);
      cyc(1, 7, 0, 0, 0);
      expect_pred("train7", 3, 1);
      reset = 1'b1;
      cyc(1, 7, 1, 7, 1);
      reset = 1'b0;
      check("midrst_valid", prediction_valid, 0);
      check("midrst_count", prediction_count, 1);
      cyc(1, 7, 0, 0, 0);
      expect_pred("after_rst7", 1, 0);

      // random phase
      for (int k = 0; k < 300; k++)
         cyc($urandom_range(0, 1), $urandom_range(0, DEPTH - 1),
             $urandom_range(0, 1), $urandom_range(0, DEPTH - 1), $urandom_range(0, 1));
      cyc(0, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/bimodal_predictor.md
BIMODAL_PREDICTOR -- requirements
Module: bimodal_predictor

Interface
REQ-001 The block SHALL have these parameters, one per line:
- DEPTH, default 16, number of table entries; power of two, at least 2.
- RANGE, default 4, number of states per saturating counter; even, at least 2.
- RESET_VALUE, default 1, initial count of every entry; at most RANGE-1.
REQ-002 Derived widths SHALL be INDEX_WIDTH = $clog2(DEPTH) and COUNT_WIDTH = $clog2(RANGE).
REQ-003 The block SHALL have these ports, one per line:
- clock             input   1            single clock; all state updates on its rising edge.
- reset             input   1            synchronous, active-high reset.
- predict_valid     input   1            lookup request this cycle.
- predict_index     input   INDEX_WIDTH  entry to look up.
- prediction_valid  output  1            prediction result valid.
- prediction_taken  output  1            predicted direction, 1 = taken.
- prediction_count  output  COUNT_WIDTH  counter value behind the prediction.
- update_valid      input   1            training request this cycle.
- update_index      input   INDEX_WIDTH  entry to train.
- update_taken      input   1            resolved direction, 1 = taken.

Function
REQ-004 The block SHALL hold DEPTH independent saturating counters, each ranging over 0 to RANGE-1.
REQ-005 A cycle with update_valid=1 and update_taken=1 SHALL increment entry update_index by 1, saturating at RANGE-1.
REQ-006 A cycle with update_valid=1 and update_taken=0 SHALL decrement entry update_index by 1, saturating at 0.
REQ-007 At each saturation bound the entry SHALL hold its value, with no wrap-around.
REQ-008 An update SHALL modify only the addressed entry; all other entries SHALL be unchanged.
REQ-009 A cycle with update_valid=0 SHALL leave the whole table unchanged.
REQ-010 Predictions SHALL have a latency of one cycle: predict_valid sampled high at edge N SHALL give prediction_valid=1 after edge N.
REQ-011 The outputs after edge N SHALL show the count of entry predict_index as sampled at edge N.
REQ-012 prediction_valid SHALL be 0 in any cycle that follows an edge where predict_valid was 0.
REQ-013 When prediction_valid=0, prediction_taken and prediction_count SHALL hold their previous values.
REQ-014 prediction_taken SHALL be 1 if and only if prediction_count >= RANGE/2.
REQ-015 If predict and update are valid in the same cycle with predict_index == update_index, the prediction SHALL return the post-update count (write-first bypass).
REQ-016 If predict and update are valid in the same cycle with different indices, both SHALL complete independently in that cycle.
REQ-017 The block SHALL accept one prediction and one update every cycle, with no back-pressure and no stall.
REQ-018 Updates to the same index in consecutive cycles SHALL accumulate; each update SHALL see the result of the previous one.

Reset
REQ-019 A clock edge with reset=1 SHALL set every table entry to RESET_VALUE.
REQ-020 A clock edge with reset=1 SHALL set prediction_valid=0, prediction_count=RESET_VALUE, and prediction_taken to (RESET_VALUE >= RANGE/2).
REQ-021 When reset is asserted mid-operation, any prediction or update sampled at that edge SHALL be discarded.
REQ-022 The first post-reset edge with reset=0 SHALL behave normally and accept requests.
REQ-023 Reset SHALL complete in one edge; the block SHALL not run a multi-cycle clear sequence.

Verification (defaults: DEPTH=16, RANGE=4, RESET_VALUE=1)
REQ-024 The bench SHALL cover reset state: reset one cycle, then predict all 16 indices -> each gives count=1, taken=0, and valid one cycle after request.
REQ-025 The bench SHALL cover upward saturation: five taken updates to index 3, then predict 3 -> count=3, taken=1; index 2 and index 4 still give count=1.
REQ-026 The bench SHALL cover downward saturation: three not-taken updates to index 3 from count=3, then predict -> count=0, taken=0; one further not-taken update keeps count=0.
REQ-027 The bench SHALL cover the bypass: with index 5 at count=1, a taken update to 5 and a predict of 5 in the same cycle -> count=2, taken=1.
REQ-028 The bench SHALL cover reset mid-operation: train index 7 to count=3, then assert reset in the same cycle as a predict of 7 and an update of 7 -> prediction_valid=0 next cycle; a later predict of 7 gives count=1.
REQ-029 The bench SHALL run a random phase of at least 200 cycles with random predict/update valids, indices and directions, checked cycle by cycle against a reference model -> zero mismatches.
